ptw_pte_writeback: RTL and testbench
====================================

# ptw_pte_writeback

Writeback engine sitting directly downstream of the Sv32 PTW A/D-update logic. It accepts one "PTE needs A/D set" request (physical PTE address, PTE as originally read, updated PTE). It performs an atomic read-compare-write on the data-memory port so the A/D update never overwrites a concurrent software change. The PTW is told whether the write landed, whether the PTE changed underneath (rewalk needed), or whether a bus fault occurred.

## Interface
- `PA_W`, default 34: physical address width (Sv32).
- `PTE_W`, default 32: PTE width.
- `clk` in 1: clock; everything is sampled on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `req_valid_i` in 1: writeback request valid.
- `req_ready_o` out 1: high only in IDLE.
- `req_paddr_i` in PA_W: PTE physical address; bits [1:0] are ignored and forced to 0.
- `req_pte_old_i` in PTE_W: PTE value the walk used.
- `req_pte_new_i` in PTE_W: PTE with A/D set.
- `flush_i` in 1: abandon the current request (sfence / trap).
- `mem_req_valid_o` out 1, `mem_req_ready_i` in 1: memory request handshake.
- `mem_req_we_o` out 1: 0 = read, 1 = write.
- `mem_req_addr_o` out PA_W, `mem_req_wdata_o` out PTE_W: request address and write data.
- `mem_lock_o` out 1: interconnect must hold exclusivity on the line while high.
- `mem_rsp_valid_i` in 1, `mem_rsp_rdata_i` in PTE_W, `mem_rsp_err_i` in 1: response, exactly one per accepted request, in order.
- `done_o` out 1: one-cycle completion pulse.
- `status_o` out 2: OK=0, CHANGED=1, FAULT=2; valid with `done_o`.
- `pte_final_o` out PTE_W: PTE now in memory (new, or the conflicting value read); valid with `done_o`.
- `busy_o` out 1: high whenever state is not IDLE.

## Operation
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RESP, DRAIN.
- IDLE:
  - On `req_valid_i && req_ready_o`, latch address, old and new PTE.
  - If new==old, go to RESP with OK and `pte_final`=old; no memory traffic.
  - Otherwise go to RD_REQ.
- RD_REQ:
  - Drive `mem_req_valid_o`=1, `mem_req_we_o`=0, `mem_lock_o`=1.
  - On ready, go to RD_WAIT.
- RD_WAIT, on response:
  - err: FAULT, `pte_final`=old, go to RESP.
  - rdata != old: CHANGED, `pte_final`=rdata, go to RESP; no write is issued.
  - rdata == old: go to WR_REQ.
- WR_REQ:
  - Drive valid, `mem_req_we_o`=1, `mem_req_wdata_o`=new, lock held.
  - On ready, go to WR_WAIT.
- WR_WAIT, on response:
  - err gives FAULT; otherwise OK with `pte_final`=new.
  - Go to RESP.
- RESP: `done_o`=1 for exactly one cycle, then IDLE.
- `mem_lock_o` rises on entry to RD_REQ and falls on the cycle after the last response of the sequence. It is never held in IDLE or RESP.
- Memory outputs hold stable while valid && !ready.
- `flush_i`, highest priority:
  - In RD_REQ/WR_REQ before the handshake: go to IDLE and drop lock.
  - In RD_WAIT/WR_WAIT: go to DRAIN. DRAIN swallows the outstanding response, then goes to IDLE.
  - Flush in the same cycle as the request-accepting handshake wins: the handshake is accepted but the request is dropped and `busy_o` stays 0.
  - A flushed request never pulses `done_o`.
  - Flush in RESP has no effect; the pulse still fires.
- `rst`: state goes to IDLE immediately. All outputs reset to 0 and latched fields reset to 0. An outstanding memory response arriving after reset is ignored.

## Timing
- Request accepted at edge N:
  - no-op request: `done_o` at N+1.
  - full sequence: `mem_req_valid_o` rises at N+1.
- Full sequence with zero-wait memory (ready=1, response the cycle after acceptance):
  - read accepted at N+1, response at N+2;
  - write valid N+3, accepted N+3, response N+4;
  - `done_o` N+5.
- CHANGED/FAULT on the read: `done_o` 1 cycle after the read response.
- `req_ready_o` returns high the cycle after the `done_o` pulse; back-to-back throughput is one request per sequence.
- All outputs are registered or decoded from state only; there is no combinational path from a `mem_*` input to a `mem_*` output.

## Structure
- Shared package `ptw_pkg`:
  - `pte_wb_status_e` {OK, CHANGED, FAULT};
  - PTE field positions: `PTE_BIT_V`=0, `PTE_BIT_A`=6, `PTE_BIT_D`=7;
  - `PA_W`/`PTE_W` defaults;
  - state enum.
- Single flat module; no sub-module is warranted.

## Test plan
- Zero-wait memory; old=0x0000_1001, new=0x0000_1041, read returns 0x0000_1001.
  - Expect read then write 0x0000_1041 to the same address.
  - Expect `done_o` at N+5, OK, `pte_final`=0x0000_1041.
  - Expect lock high N+1..N+4.
- Same request, but the read returns 0x0000_1000 (V cleared by software).
  - Expect no write, CHANGED, `pte_final`=0x0000_1000.
- Read error.
  - Expect FAULT, no write issued, lock dropped.
- old==new=0x0000_10C1.
  - Expect zero `mem_req_valid_o` cycles and `done_o` at N+1 with OK.
- `mem_req_ready_i` low for 3 cycles on the write.
  - Expect addr/wdata/we stable throughout; `flush_i` in RD_WAIT leads to DRAIN, the response is swallowed, no `done_o`, and `req_ready_o` rises the cycle after the response.
- `rst` asserted in WR_WAIT.
  - Expect all outputs 0 next cycle; a late response is ignored; the next request completes normally.

Source files
------------

// File: rtl/ptw_pkg.sv
// Shared Sv32 page-table-walker types: writeback status, FSM states, PTE bit positions.
package ptw_pkg;

  localparam int DEF_PA_W  = 34;
  localparam int DEF_PTE_W = 32;

  localparam int PTE_BIT_V = 0;
  localparam int PTE_BIT_A = 6;
  localparam int PTE_BIT_D = 7;

  typedef enum logic [1:0] {
    PTE_WB_OK      = 2'd0,
    PTE_WB_CHANGED = 2'd1,
    PTE_WB_FAULT   = 2'd2
  } pte_wb_status_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WR_WAIT = 3'd4,
    S_RESP    = 3'd5,
    S_DRAIN   = 3'd6
  } pte_wb_state_e;

endpackage

// File: rtl/ptw_pte_writeback_if.sv
// PTW request/response and locked data-memory port of the PTE writeback engine.
interface ptw_pte_writeback_if #(
  parameter int PA_W  = ptw_pkg::DEF_PA_W,
  parameter int PTE_W = ptw_pkg::DEF_PTE_W
);
  logic             req_valid_i;
  logic             req_ready_o;
  logic [PA_W-1:0]  req_paddr_i;
  logic [PTE_W-1:0] req_pte_old_i;
  logic [PTE_W-1:0] req_pte_new_i;
  logic             flush_i;
  logic             mem_req_valid_o;
  logic             mem_req_ready_i;
  logic             mem_req_we_o;
  logic [PA_W-1:0]  mem_req_addr_o;
  logic [PTE_W-1:0] mem_req_wdata_o;
  logic             mem_lock_o;
  logic             mem_rsp_valid_i;
  logic [PTE_W-1:0] mem_rsp_rdata_i;
  logic             mem_rsp_err_i;
  logic             done_o;
  logic [1:0]       status_o;
  logic [PTE_W-1:0] pte_final_o;
  logic             busy_o;

  // Engine side
  modport slave (
    input  req_valid_i, req_paddr_i, req_pte_old_i, req_pte_new_i, flush_i,
    input  mem_req_ready_i, mem_rsp_valid_i, mem_rsp_rdata_i, mem_rsp_err_i,
    output req_ready_o, mem_req_valid_o, mem_req_we_o, mem_req_addr_o,
    output mem_req_wdata_o, mem_lock_o, done_o, status_o, pte_final_o, busy_o
  );

  // PTW + memory side
  modport master (
    output req_valid_i, req_paddr_i, req_pte_old_i, req_pte_new_i, flush_i,
    output mem_req_ready_i, mem_rsp_valid_i, mem_rsp_rdata_i, mem_rsp_err_i,
    input  req_ready_o, mem_req_valid_o, mem_req_we_o, mem_req_addr_o,
    input  mem_req_wdata_o, mem_lock_o, done_o, status_o, pte_final_o, busy_o
  );
endinterface

// File: rtl/ptw_pte_writeback.sv
// Atomic read-compare-write of a PTE A/D update under a held interconnect lock.
// Reports OK / CHANGED (software raced the walk) / FAULT; a flushed request never reports.
module ptw_pte_writeback
  import ptw_pkg::*;
#(
  parameter int PA_W  = DEF_PA_W,
  parameter int PTE_W = DEF_PTE_W
) (
  input  logic               clk,
  input  logic               rst,
  ptw_pte_writeback_if.slave wb
);

  pte_wb_state_e  state_q;
  pte_wb_status_e status_q;
  logic [PA_W-1:0]  addr_q;
  logic [PTE_W-1:0] old_q, new_q, wdata_q, final_q;
  logic mem_vld_q, we_q, lock_q, done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      status_q  <= PTE_WB_OK;
      addr_q    <= '0;
      old_q     <= '0;
      new_q     <= '0;
      wdata_q   <= '0;
      final_q   <= '0;
      mem_vld_q <= 1'b0;
      we_q      <= 1'b0;
      lock_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (wb.req_valid_i) begin
            addr_q <= wb.req_paddr_i & ~PA_W'(3);
            old_q  <= wb.req_pte_old_i;
            new_q  <= wb.req_pte_new_i;
            if (wb.flush_i) begin
              state_q <= S_IDLE;
            end else if (wb.req_pte_new_i == wb.req_pte_old_i) begin
              state_q  <= S_RESP;
              done_q   <= 1'b1;
              status_q <= PTE_WB_OK;
              final_q  <= wb.req_pte_old_i;
            end else begin
              state_q   <= S_RD_REQ;
              mem_vld_q <= 1'b1;
              we_q      <= 1'b0;
              lock_q    <= 1'b1;
            end
          end
        end
        S_RD_REQ, S_WR_REQ: begin
          if (wb.flush_i) begin
            mem_vld_q <= 1'b0;
            // An already-accepted request still owes a response, so drain it under lock.
            if (wb.mem_req_ready_i) begin
              state_q <= S_DRAIN;
            end else begin
              state_q <= S_IDLE;
              lock_q  <= 1'b0;
            end
          end else if (wb.mem_req_ready_i) begin
            mem_vld_q <= 1'b0;
            state_q   <= (state_q == S_RD_REQ) ? S_RD_WAIT : S_WR_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (wb.mem_rsp_valid_i) begin
            if (wb.flush_i) begin
              state_q <= S_IDLE;
              lock_q  <= 1'b0;
            end else if (wb.mem_rsp_err_i) begin
              state_q  <= S_RESP;
              done_q   <= 1'b1;
              status_q <= PTE_WB_FAULT;
              final_q  <= old_q;
              lock_q   <= 1'b0;
            end else if (wb.mem_rsp_rdata_i != old_q) begin
              state_q  <= S_RESP;
              done_q   <= 1'b1;
              status_q <= PTE_WB_CHANGED;
              final_q  <= wb.mem_rsp_rdata_i;
              lock_q   <= 1'b0;
            end else begin
              state_q   <= S_WR_REQ;
              mem_vld_q <= 1'b1;
              we_q      <= 1'b1;
              wdata_q   <= new_q;
            end
          end else if (wb.flush_i) begin
            state_q <= S_DRAIN;
          end
        end
        S_WR_WAIT: begin
          if (wb.mem_rsp_valid_i) begin
            lock_q <= 1'b0;
            if (wb.flush_i) begin
              state_q <= S_IDLE;
            end else begin
              state_q  <= S_RESP;
              done_q   <= 1'b1;
              status_q <= wb.mem_rsp_err_i ? PTE_WB_FAULT : PTE_WB_OK;
              final_q  <= wb.mem_rsp_err_i ? old_q : new_q;
            end
          end else if (wb.flush_i) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (wb.mem_rsp_valid_i) begin
            state_q <= S_IDLE;
            lock_q  <= 1'b0;
          end
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wb.req_ready_o     = (state_q == S_IDLE);
  assign wb.busy_o          = (state_q != S_IDLE);
  assign wb.mem_req_valid_o = mem_vld_q;
  assign wb.mem_req_we_o    = we_q;
  assign wb.mem_req_addr_o  = addr_q;
  assign wb.mem_req_wdata_o = wdata_q;
  assign wb.mem_lock_o      = lock_q;
  assign wb.done_o          = done_q;
  assign wb.status_o        = status_q;
  assign wb.pte_final_o     = final_q;

endmodule

// File: tb/tb_ptw_pte_writeback.sv
// Randomized + directed bench for ptw_pte_writeback against a transaction-level outcome model.
module tb_ptw_pte_writeback;
  import ptw_pkg::*;

  localparam int PA_W  = DEF_PA_W;
  localparam int PTE_W = DEF_PTE_W;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  ptw_pte_writeback_if #(.PA_W(PA_W), .PTE_W(PTE_W)) wb ();
  ptw_pte_writeback #(.PA_W(PA_W), .PTE_W(PTE_W)) dut (.clk(clk), .rst(rst), .wb(wb));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Memory configuration for the current request (written only by the stimulus process)
  logic [PTE_W-1:0] cfg_rd_data;
  bit               cfg_rd_err, cfg_wr_err;
  int               cfg_rd_stall, cfg_wr_stall, cfg_rd_dly, cfg_wr_dly;
  logic [PA_W-1:0]  exp_addr;
  logic [PTE_W-1:0] exp_wdata;

  // Memory responder and monitor state (written only by the responder process)
  int   pend_cnt = 0, vcyc = 0, hs_cnt = 0, wr_cnt = 0, done_cnt = 0, vld_cnt = 0;
  int   rsp_lbl = 0, done_lbl = 0, lock_rise = 0, lock_last = 0;
  bit   pend_live = 0, pend_err = 0, prev_stall = 0, prev_dist = 0, prev_lock = 0, done_lock = 0;
  logic [PTE_W-1:0] pend_data, last_wdata, done_fin, prev_wdata;
  logic [PA_W-1:0]  prev_addr;
  logic [1:0]       done_st;
  logic             prev_we;

  always @(negedge clk) begin
    int  lbl;
    bit  rdy;
    #1;
    lbl = cyc + 1;  // the rising edge that will sample what is visible now
    if (prev_stall && !prev_dist) begin
      chk("stall_valid", wb.mem_req_valid_o, 1'b1);
      chk("stall_addr",  wb.mem_req_addr_o, prev_addr);
      chk("stall_we",    wb.mem_req_we_o, prev_we);
      chk("stall_wdata", wb.mem_req_wdata_o, prev_wdata);
    end
    if (pend_cnt > 0) pend_cnt--;
    if (pend_live && pend_cnt == 0) begin
      wb.mem_rsp_valid_i = 1'b1;
      wb.mem_rsp_err_i   = pend_err;
      wb.mem_rsp_rdata_i = pend_data;
      pend_live = 0;
      rsp_lbl   = lbl;
    end else begin
      wb.mem_rsp_valid_i = 1'b0;
      wb.mem_rsp_err_i   = 1'($urandom_range(0, 1));
      wb.mem_rsp_rdata_i = $urandom;
    end
    if (wb.mem_req_valid_o) begin
      rdy = (vcyc >= (wb.mem_req_we_o ? cfg_wr_stall : cfg_rd_stall));
      vcyc++;
      vld_cnt++;
    end else begin
      rdy  = 1'($urandom_range(0, 1));
      vcyc = 0;
    end
    wb.mem_req_ready_i = rdy;
    if (wb.mem_req_valid_o && rdy) begin
      hs_cnt++;
      vcyc = 0;
      chk("mem_addr", wb.mem_req_addr_o, exp_addr);
      pend_live = 1;
      if (wb.mem_req_we_o) begin
        wr_cnt++;
        last_wdata = wb.mem_req_wdata_o;
        pend_err   = cfg_wr_err;
        pend_data  = $urandom;
        pend_cnt   = 1 + cfg_wr_dly;
      end else begin
        pend_err  = cfg_rd_err;
        pend_data = cfg_rd_data;
        pend_cnt  = 1 + cfg_rd_dly;
      end
    end
    prev_stall = wb.mem_req_valid_o && !rdy;
    prev_dist  = rst || wb.flush_i;
    prev_addr  = wb.mem_req_addr_o;
    prev_we    = wb.mem_req_we_o;
    prev_wdata = wb.mem_req_wdata_o;
    if (wb.done_o) begin
      done_cnt++;
      done_lbl  = lbl;
      done_st   = wb.status_o;
      done_fin  = wb.pte_final_o;
      done_lock = wb.mem_lock_o;
    end
    if (wb.mem_lock_o) begin
      if (!prev_lock) lock_rise = lbl;
      lock_last = lbl;
    end
    prev_lock = wb.mem_lock_o;
    if (!rst) chk("lock_outside_seq", wb.mem_lock_o & (~wb.busy_o | wb.done_o), 1'b0);
  end

  // Outcome of one request from the read-compare-write rules, zero-wait latency.
  function automatic void ref_model(input logic [31:0] o, n, mv, input bit rerr, werr,
                                    output logic [1:0] st, output logic [31:0] fin,
                                    output int nreq, output int lat);
    if (o == n)         begin st = 2'd0; fin = o;  nreq = 0; lat = 1; end
    else if (rerr)      begin st = 2'd2; fin = o;  nreq = 1; lat = 3; end
    else if (mv != o)   begin st = 2'd1; fin = mv; nreq = 1; lat = 3; end
    else if (werr)      begin st = 2'd2; fin = o;  nreq = 2; lat = 5; end
    else                begin st = 2'd0; fin = n;  nreq = 2; lat = 5; end
  endfunction

  task automatic do_req(input logic [PA_W-1:0] a, input logic [31:0] o, n, input bit fl,
                        output int acc);
    int i;
    i = 0;
    @(negedge clk);
    while (!wb.req_ready_o && i < 60) begin
      @(negedge clk);
      i++;
    end
    if (i == 60) chk("req_ready_timeout", 1'b1, 1'b0);
    exp_addr  = a & ~PA_W'(3);
    exp_wdata = n;
    wb.req_valid_i   = 1'b1;
    wb.req_paddr_i   = a;
    wb.req_pte_old_i = o;
    wb.req_pte_new_i = n;
    wb.flush_i       = fl;
    @(posedge clk);
    #1;
    acc = cyc;
    wb.req_valid_i = 1'b0;
    wb.flush_i     = 1'b0;
  endtask

  task automatic wait_done(input int base);
    int i;
    for (i = 0; i < 60; i++) begin
      @(negedge clk);
      #2;
      if (done_cnt > base) break;
    end
    if (i == 60) chk("done_timeout", 1'b1, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  task automatic set_mem(input logic [31:0] rd, input bit re, we, input int rs, ws, rd_d, wr_d);
    cfg_rd_data = rd; cfg_rd_err = re; cfg_wr_err = we;
    cfg_rd_stall = rs; cfg_wr_stall = ws; cfg_rd_dly = rd_d; cfg_wr_dly = wr_d;
  endtask

  // One request checked end-to-end against the reference model.
  task automatic run_one(input string tag, input logic [PA_W-1:0] a, input logic [31:0] o, n);
    int acc, b_done, b_hs, b_wr, nreq, lat;
    logic [1:0]  st;
    logic [31:0] fin;
    ref_model(o, n, cfg_rd_data, cfg_rd_err, cfg_wr_err, st, fin, nreq, lat);
    if (nreq >= 1) lat += cfg_rd_stall + cfg_rd_dly;
    if (nreq == 2) lat += cfg_wr_stall + cfg_wr_dly;
    b_done = done_cnt; b_hs = hs_cnt; b_wr = wr_cnt;
    do_req(a, o, n, 1'b0, acc);
    wait_done(b_done);
    chk({tag, "_done_count"}, done_cnt - b_done, 1);
    chk({tag, "_latency"}, done_lbl - acc, lat);
    chk({tag, "_status"}, done_st, st);
    chk({tag, "_pte_final"}, done_fin, fin);
    chk({tag, "_mem_reqs"}, hs_cnt - b_hs, nreq);
    chk({tag, "_writes"}, wr_cnt - b_wr, (nreq == 2) ? 1 : 0);
    if (nreq == 2) chk({tag, "_wdata"}, last_wdata, n);
  endtask

  initial begin
    int acc, b_done, b_hs, b_vld, rdy_lbl;
    logic [PA_W-1:0] a;
    logic [31:0] o, n, mv;
    rst = 1'b1;
    wb.req_valid_i = 1'b0; wb.req_paddr_i = '0; wb.req_pte_old_i = '0;
    wb.req_pte_new_i = '0; wb.flush_i = 1'b0;
    set_mem(32'h0, 0, 0, 0, 0, 0, 0);
    exp_addr = '0; exp_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", wb.req_ready_o, 1'b1);
    chk("rst_busy", wb.busy_o, 1'b0);
    chk("rst_done", wb.done_o, 1'b0);
    chk("rst_mem_valid", wb.mem_req_valid_o, 1'b0);
    chk("rst_lock", wb.mem_lock_o, 1'b0);
    chk("rst_status", wb.status_o, 2'd0);
    chk("rst_final", wb.pte_final_o, 32'h0);
    chk("rst_addr", wb.mem_req_addr_o, 34'h0);
    @(negedge clk);
    rst = 1'b0;

    // Clean A/D update, zero-wait memory
    set_mem(32'h0000_1001, 0, 0, 0, 0, 0, 0);
    run_one("full_ok", 34'h1_0000_0403, 32'h0000_1001, 32'h0000_1041);
    chk("full_lock_rise", lock_rise - (done_lbl - 5), 1);
    chk("full_lock_last", lock_last - (done_lbl - 5), 4);

    // Software cleared V between walk and writeback
    mv = 32'h0000_1001;
    mv[PTE_BIT_V] = 1'b0;
    set_mem(mv, 0, 0, 0, 0, 0, 0);
    run_one("changed", 34'h1_0000_0400, 32'h0000_1001, 32'h0000_1041);

    set_mem(32'h0000_1001, 1, 0, 0, 0, 0, 0);
    run_one("rd_fault", 34'h0_0000_2000, 32'h0000_1001, 32'h0000_1041);
    chk("rd_fault_lock_at_done", done_lock, 1'b0);
    chk("rd_fault_lock_last", lock_last - (done_lbl - 3), 2);

    b_vld = vld_cnt;
    run_one("noop", 34'h0_0000_3000, 32'h0000_10C1, 32'h0000_10C1);
    chk("noop_valid_cycles", vld_cnt - b_vld, 0);

    // Write held off three cycles; stability checked by the responder each stalled cycle
    set_mem(32'h0000_1001, 0, 0, 0, 3, 0, 0);
    run_one("wr_stall", 34'h0_0000_4004, 32'h0000_1001, 32'h0000_10C1);

    // Flush while the read is outstanding
    set_mem(32'h0000_1001, 0, 0, 0, 0, 3, 0);
    b_done = done_cnt; b_hs = hs_cnt;
    do_req(34'h0_0000_5000, 32'h0000_1001, 32'h0000_1041, 1'b0, acc);
    repeat (2) @(negedge clk);
    wb.flush_i = 1'b1;
    @(posedge clk);
    #1;
    wb.flush_i = 1'b0;
    rdy_lbl = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #2;
      if (wb.req_ready_o) begin
        rdy_lbl = cyc + 1;
        break;
      end
    end
    chk("drain_ready_after_rsp", rdy_lbl - rsp_lbl, 1);
    chk("drain_rsp_label", rsp_lbl - acc, 5);
    repeat (3) @(negedge clk);
    chk("drain_no_done", done_cnt - b_done, 0);
    chk("drain_no_write", hs_cnt - b_hs, 1);

    // Flush coincident with acceptance drops the request
    set_mem(32'h0000_1001, 0, 0, 0, 0, 0, 0);
    b_done = done_cnt; b_hs = hs_cnt;
    do_req(34'h0_0000_6000, 32'h0000_1001, 32'h0000_1041, 1'b1, acc);
    chk("flush_accept_busy", wb.busy_o, 1'b0);
    repeat (6) @(negedge clk);
    chk("flush_accept_no_done", done_cnt - b_done, 0);
    chk("flush_accept_no_mem", hs_cnt - b_hs, 0);

    // Reset while waiting for the write response; the late response must be ignored
    set_mem(32'h0000_1001, 0, 0, 0, 0, 0, 3);
    b_done = done_cnt;
    do_req(34'h0_0000_7000, 32'h0000_1001, 32'h0000_1041, 1'b0, acc);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_busy", wb.busy_o, 1'b0);
    chk("mid_rst_lock", wb.mem_lock_o, 1'b0);
    chk("mid_rst_valid", wb.mem_req_valid_o, 1'b0);
    chk("mid_rst_we", wb.mem_req_we_o, 1'b0);
    chk("mid_rst_wdata", wb.mem_req_wdata_o, 32'h0);
    chk("mid_rst_done", wb.done_o, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("late_rsp_ignored_done", done_cnt - b_done, 0);
    chk("late_rsp_ignored_busy", wb.busy_o, 1'b0);
    set_mem(32'h0000_2001, 0, 0, 0, 0, 0, 0);
    run_one("after_rst", 34'h0_0000_8000, 32'h0000_2001, 32'h0000_20C1);

    // Randomized requests against the outcome model
    for (int it = 0; it < 40; it++) begin
      a = 34'h2_0000_0000 | (PA_W'($urandom_range(0, 255)) << 2) | PA_W'($urandom_range(0, 3));
      o = $urandom;
      o[PTE_BIT_A] = 1'b0;
      o[PTE_BIT_D] = 1'b0;
      n = o;
      if ($urandom_range(0, 5) != 0) begin
        n[PTE_BIT_A] = 1'b1;
        n[PTE_BIT_D] = 1'($urandom_range(0, 1));
      end
      mv = ($urandom_range(0, 2) == 0) ? (o ^ (32'h1 << $urandom_range(0, 31))) : o;
      set_mem(mv, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
              $urandom_range(0, 2), $urandom_range(0, 2),
              $urandom_range(0, 2), $urandom_range(0, 2));
      run_one("rand", a, o, n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
